// File: rtl/rp_unsigned_multiplier_8_pkg.sv
// Shared types and the single-step Russian-peasant update for rp_unsigned_multiplier_8.
// The stage record is sized for the widest supported operand; narrower builds leave upper bits at zero.
package rp_mul_pkg;

  localparam int RP_DEFAULT_WIDTH = 8;
  localparam int RP_MAX_WIDTH     = 16;

  typedef struct packed {
    logic                      v;
    logic [RP_MAX_WIDTH-1:0]   a;
    logic [2*RP_MAX_WIDTH-1:0] b;
    logic [2*RP_MAX_WIDTH-1:0] acc;
  } rp_stage_t;

  // Halve a, double b, and accumulate b when a is odd.
  function automatic rp_stage_t rp_step(input rp_stage_t s);
    rp_stage_t n;
    n.v   = s.v;
    n.a   = s.a >> 1;
    n.b   = s.b << 1;
    n.acc = s.acc + (s.a[0] ? s.b : '0);
    return n;
  endfunction

endpackage

// File: rtl/rp_unsigned_multiplier_8_if.sv
// Operand/result bus for rp_unsigned_multiplier_8.
// Handshake: A/B are taken on every rising edge where in_valid=1; there is no ready, so the
// source never stalls. out_valid=1 marks a cycle where product carries a result, else product=0.
interface rp_unsigned_multiplier_8_if #(
  parameter int WIDTH = 8
);
  logic               in_valid;
  logic [WIDTH-1:0]   A;
  logic [WIDTH-1:0]   B;
  logic               out_valid;
  logic [2*WIDTH-1:0] product;

  modport master (output in_valid, output A, output B, input out_valid, input product);
  modport slave  (input in_valid, input A, input B, output out_valid, output product);
endinterface

// File: rtl/rp_unsigned_multiplier_8_stage.sv
// One registered Russian-peasant step with synchronous active-high reset.
import rp_mul_pkg::*;

module rp_mul_stage (
  input  logic      clk,
  input  logic      rst,
  input  rp_stage_t d,
  output rp_stage_t q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else begin
      q <= rp_step(d);
    end
  end

endmodule

// File: rtl/rp_unsigned_multiplier_8.sv
// Pipelined unsigned WIDTH x WIDTH Russian-peasant multiplier, one result per cycle.
// Build option RP_MUL_OUTPUT_REG_EN adds one output register (latency WIDTH+1 instead of WIDTH).
import rp_mul_pkg::*;

module rp_unsigned_multiplier_8 #(
  parameter int WIDTH = RP_DEFAULT_WIDTH
) (
  input logic                      clk,
  input logic                      rst,
  rp_unsigned_multiplier_8_if.slave bus
);

  rp_stage_t ld;
  rp_stage_t pipe [WIDTH];

  always_comb begin
    ld                = '0;
    ld.v              = bus.in_valid;
    ld.a[WIDTH-1:0]   = bus.A;
    ld.b[WIDTH-1:0]   = bus.B;
  end

  // Each stage register already holds the state after its own step, so WIDTH registers give WIDTH steps.
  for (genvar k = 0; k < WIDTH; k++) begin : g_stage
    rp_stage_t d;
    if (k == 0) begin : g_first
      assign d = ld;
    end else begin : g_next
      assign d = pipe[k-1];
    end
    rp_mul_stage u_stage (
      .clk (clk),
      .rst (rst),
      .d   (d),
      .q   (pipe[k])
    );
  end

  rp_stage_t          last;
  logic               res_v;
  logic [2*WIDTH-1:0] res_p;
  logic               unused_last;

  assign last        = pipe[WIDTH-1];
  assign res_v       = last.v;
  assign res_p       = last.v ? last.acc[2*WIDTH-1:0] : '0;
  assign unused_last = ^{last.a, last.b, last.acc};

`ifdef RP_MUL_OUTPUT_REG_EN
  logic               out_v_q;
  logic [2*WIDTH-1:0] out_p_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_v_q <= 1'b0;
      out_p_q <= '0;
    end else begin
      out_v_q <= res_v;
      out_p_q <= res_p;
    end
  end

  assign bus.out_valid = out_v_q;
  assign bus.product   = out_p_q;
`else
  assign bus.out_valid = res_v;
  assign bus.product   = res_p;
`endif

endmodule

// File: tb/tb_rp_unsigned_multiplier_8.sv
// Self-checking bench for rp_unsigned_multiplier_8 (latency follows RP_MUL_OUTPUT_REG_EN).
`timescale 1ns/1ps

module tb_rp_unsigned_multiplier_8;

  localparam int W = 8;
`ifdef RP_MUL_OUTPUT_REG_EN
  localparam int LAT = W + 1;
`else
  localparam int LAT = W;
`endif

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] exp;
    string          name;
  } vec_t;

  logic clk;
  logic rst;

  rp_unsigned_multiplier_8_if #(.WIDTH(W)) bus ();

  rp_unsigned_multiplier_8 #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [2*W-1:0] exp_q[$];
  logic           vld_q[$];

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.in_valid = v;
    bus.A        = a;
    bus.B        = b;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // one isolated pulse, checked exactly LAT cycles later and one cycle after
  task automatic run_single(input vec_t t);
    drive(1'b1, t.a, t.b);
    tick();
    drive(1'b0, '0, '0);
    for (int i = 1; i < LAT; i++) begin
      chk({t.name, " early_valid"}, {31'b0, bus.out_valid}, 32'd0);
      tick();
    end
    chk({t.name, " valid"}, {31'b0, bus.out_valid}, 32'd1);
    chk({t.name, " product"}, {16'b0, bus.product}, {16'b0, t.exp});
    tick();
    chk({t.name, " valid_drop"}, {31'b0, bus.out_valid}, 32'd0);
    chk({t.name, " product_zero"}, {16'b0, bus.product}, 32'd0);
  endtask

  vec_t vecs [8];

  initial begin
    vecs[0] = '{a: 8'd98,  b: 8'd115, exp: 16'd11270, name: "v98x115"};
    vecs[1] = '{a: 8'd0,   b: 8'd255, exp: 16'd0,     name: "v0x255"};
    vecs[2] = '{a: 8'd255, b: 8'd0,   exp: 16'd0,     name: "v255x0"};
    vecs[3] = '{a: 8'd255, b: 8'd255, exp: 16'd65025, name: "v255x255"};
    vecs[4] = '{a: 8'd1,   b: 8'd1,   exp: 16'd1,     name: "v1x1"};
    vecs[5] = '{a: 8'd128, b: 8'd2,   exp: 16'd256,   name: "v128x2"};
    vecs[6] = '{a: 8'd170, b: 8'd99,  exp: 16'd16830, name: "v170x99"};
    vecs[7] = '{a: 8'd229, b: 8'd42,  exp: 16'd9618,  name: "v229x42"};

    // reset held 3 cycles with a valid request that must be ignored
    rst = 1'b1;
    drive(1'b1, 8'd7, 8'd9);
    tick();
    chk("rst_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rst_product", {16'b0, bus.product}, 32'd0);
    tick();
    tick();
    drive(1'b0, '0, '0);
    rst = 1'b0;
    for (int i = 0; i < LAT + 2; i++) begin
      chk("post_rst_idle_valid", {31'b0, bus.out_valid}, 32'd0);
      chk("post_rst_idle_product", {16'b0, bus.product}, 32'd0);
      tick();
    end

    // table of isolated operations
    for (int i = 0; i < 8; i++) begin
      run_single(vecs[i]);
    end

    // back-to-back pair on consecutive cycles
    drive(1'b1, 8'd170, 8'd99);
    tick();
    drive(1'b1, 8'd229, 8'd42);
    tick();
    drive(1'b0, '0, '0);
    for (int i = 2; i < LAT; i++) tick();
    chk("b2b_first_valid", {31'b0, bus.out_valid}, 32'd1);
    chk("b2b_first_product", {16'b0, bus.product}, 32'd16830);
    tick();
    chk("b2b_second_valid", {31'b0, bus.out_valid}, 32'd1);
    chk("b2b_second_product", {16'b0, bus.product}, 32'd9618);
    tick();
    chk("b2b_drop", {31'b0, bus.out_valid}, 32'd0);

    // reset in the middle of four in-flight operations
    begin
      int seen;
      seen = 0;
      drive(1'b1, 8'd11, 8'd3);
      tick();
      drive(1'b1, 8'd200, 8'd200);
      tick();
      rst = 1'b1;
      drive(1'b1, 8'd5, 8'd6);
      tick();
      drive(1'b1, 8'd77, 8'd88);
      tick();
      rst = 1'b0;
      drive(1'b0, '0, '0);
      for (int i = 0; i < 2 * LAT + 2; i++) begin
        if (bus.out_valid !== 1'b0) seen++;
        tick();
      end
      chk("flush_no_valid_count", seen, 32'd0);
    end
    run_single('{a: 8'd12, b: 8'd13, exp: 16'd156, name: "after_flush"});

    // streaming with random bubbles against a delayed reference model
    vld_q.delete();
    exp_q.delete();
    for (int i = 0; i < 3000 + LAT; i++) begin
      logic v;
      logic [W-1:0] a;
      logic [W-1:0] b;
      v = (i < 3000) && ($urandom_range(0, 9) < 7);
      a = W'($urandom_range(0, 255));
      b = W'($urandom_range(0, 255));
      if (i % 500 == 0 && i < 3000) begin
        a = 8'd255;
        b = 8'd255;
        v = 1'b1;
      end
      drive(v, a, b);
      vld_q.push_back(v);
      if (v) exp_q.push_back(16'(a) * 16'(b));
      tick();
      if (vld_q.size() == LAT) begin
        logic ev;
        ev = vld_q.pop_front();
        chk("stream_valid", {31'b0, bus.out_valid}, {31'b0, ev});
        if (ev) begin
          logic [2*W-1:0] ep;
          ep = exp_q.pop_front();
          chk("stream_product", {16'b0, bus.product}, {16'b0, ep});
        end else begin
          chk("stream_bubble_zero", {16'b0, bus.product}, 32'd0);
        end
      end
    end
    drive(1'b0, '0, '0);
    chk("stream_queue_drained", exp_q.size(), 32'd0);

    // final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
